// File: rtl/mult_pkg.sv
// Shared definitions for the signed sequential multiplier.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents: alu operation codes, controller state encoding, counter width helper.
package mult_pkg;

  // Alu operation select. Codes 3'b011 and 3'b100 are reserved and never driven.
  localparam logic [2:0] ALU_PASS = 3'b000;  // result = product high half
  localparam logic [2:0] ALU_ADD  = 3'b001;  // high half + multiplicand
  localparam logic [2:0] ALU_SUB  = 3'b010;  // high half - multiplicand

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } stateT;

  // Ceiling log2, minimum 1, used to size the iteration counter.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth sequencing controller: drives an external alu and owns the product register.
// Latency: start accepted at edge 0, done in cycle 2n+1 (BOOTH_SKIP_EN: n + add/sub iterations + 1).
// Backpressure: none; start is only sampled in IDLE, so starts while busy or during done are dropped.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   start              request pulse, accepted only in IDLE
//   multiplicandIn     signed multiplicand captured on an accepted start
//   multiplierIn       signed multiplier captured on an accepted start
//   busy               high from the cycle after an accepted start through DONE
//   done               one-cycle pulse, product valid in that cycle
//   product            signed 2n-bit result, held until the next result is written
//   aluSetting         operation select to the alu (PASS/ADD/SUB)
//   multiplicand       registered multiplicand to the alu
//   aluProductHigh     product register high half to the alu
//   aluResult          alu result, combinational in the same cycle
//   carryOut           alu carry, not needed by this controller
//
// Build option: define BOOTH_SKIP_EN to skip the EVAL cycle on 00/11 Booth pairs.
module booth_seq_ctrl
  import mult_pkg::*;
#(
  parameter int n = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [n-1:0]     multiplicandIn,
  input  logic [n-1:0]     multiplierIn,
  output logic             busy,
  output logic             done,
  output logic [2*n-1:0]   product,
  output logic [2:0]       aluSetting,
  output logic [n-1:0]     multiplicand,
  output logic [n-1:0]     aluProductHigh,
  input  logic [n-1:0]     aluResult,
  input  logic             carryOut
);

  localparam int cntW = clog2(n);

  stateT           state;
  stateT           stateNext;

  // pReg = {high[n], low[n], q-1}
  logic [2*n:0]    pReg;
  logic [n-1:0]    mcandReg;
  logic [cntW-1:0] count;
  logic            guard;
  logic [2*n-1:0]  productReg;

  logic [n-1:0]    high;
  logic [1:0]      pair;
  logic [2*n:0]    pShift;
  logic            lastIter;
  logic [n-1:0]    addendB;
  logic            ovf;
  logic            guardEval;

  // Sign overflow is computed from operand signs, so the alu carry is not consumed.
  logic            unusedCarry;
  assign unusedCarry = carryOut;

  assign high     = pReg[2*n:n+1];
  assign pair     = pReg[1:0];
  // The guard bit holds the true sign of the (n+1)-bit alu result, so shifting it in
  // keeps -2^(n-1) * -2^(n-1) exact.
  assign pShift   = {guard, pReg[2*n:1]};
  assign lastIter = (count == cntW'(n - 1));

  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign product        = productReg;
  assign multiplicand   = mcandReg;
  assign aluProductHigh = high;

  // Next state, alu select and guard computation.
  always_comb begin
    stateNext  = state;
    aluSetting = ALU_PASS;
    addendB    = mcandReg;
    ovf        = 1'b0;
    guardEval  = high[n-1];

    case (state)
      IDLE: begin
        if (start) begin
`ifdef BOOTH_SKIP_EN
          // First pair is {multiplierIn[0], 0}; 00 needs no alu cycle.
          stateNext = multiplierIn[0] ? EVAL : SHIFT;
`else
          stateNext = EVAL;
`endif
        end
      end

      EVAL: begin
        case (pair)
          2'b01:   aluSetting = ALU_ADD;
          2'b10:   aluSetting = ALU_SUB;
          default: aluSetting = ALU_PASS;
        endcase
        // Subtraction is a + ~b + 1, so its overflow follows the add rule on ~b.
        if (pair == 2'b10) addendB = ~mcandReg;
        if (pair[1] != pair[0]) begin
          ovf       = (high[n-1] == addendB[n-1]) && (aluResult[n-1] != high[n-1]);
          guardEval = aluResult[n-1] ^ ovf;
        end
        stateNext = SHIFT;
      end

      SHIFT: begin
        if (lastIter) begin
          stateNext = DONE;
        end else begin
`ifdef BOOTH_SKIP_EN
          // Guard already equals the new high[n-1] after a shift, so a skipped
          // iteration can reuse it unchanged.
          stateNext = (pShift[1] == pShift[0]) ? SHIFT : EVAL;
`else
          stateNext = EVAL;
`endif
        end
      end

      DONE: stateNext = IDLE;

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pReg       <= '0;
      mcandReg   <= '0;
      count      <= '0;
      guard      <= 1'b0;
      productReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pReg     <= {{n{1'b0}}, multiplierIn, 1'b0};
            mcandReg <= multiplicandIn;
            count    <= '0;
            guard    <= 1'b0;
          end
        end

        EVAL: begin
          pReg[2*n:n+1] <= aluResult;
          guard         <= guardEval;
        end

        SHIFT: begin
          pReg  <= pShift;
          count <= count + 1'b1;
          // Written on the way into DONE so the result is visible during the done pulse.
          if (lastIter) productReg <= pShift[2*n:1];
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl with a behavioural alu beside it.
// Latency: n/a.  Backpressure: n/a.
// Expected products come from signed multiplication, alu ops from multiplier bit pairs.
module tb_booth_seq_ctrl;
  import mult_pkg::*;

  localparam int N = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [N-1:0]     multiplicandIn;
  logic [N-1:0]     multiplierIn;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   product;
  logic [2:0]       aluSetting;
  logic [N-1:0]     multiplicand;
  logic [N-1:0]     aluProductHigh;
  logic [N-1:0]     aluResult;
  logic             carryOut;

  int total  = 0;
  int passed = 0;

  booth_seq_ctrl #(.n(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .multiplicandIn (multiplicandIn),
    .multiplierIn   (multiplierIn),
    .busy           (busy),
    .done           (done),
    .product        (product),
    .aluSetting     (aluSetting),
    .multiplicand   (multiplicand),
    .aluProductHigh (aluProductHigh),
    .aluResult      (aluResult),
    .carryOut       (carryOut)
  );

  always #5 clk = ~clk;

  // Behavioural alu that sits beside the controller at the multiplier top.
  always_comb begin
    aluResult = aluProductHigh;
    carryOut  = 1'b0;
    case (aluSetting)
      ALU_ADD: {carryOut, aluResult} = {1'b0, aluProductHigh} + {1'b0, multiplicand};
      ALU_SUB: {carryOut, aluResult} = {1'b0, aluProductHigh} + {1'b0, ~multiplicand} + 9'd1;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Reference model: Booth op for iteration i from multiplier bits (b[i], b[i-1]), b[-1] = 0.
  function automatic logic [2:0] boothOp(input logic [N-1:0] b, input int i);
    logic [N:0] ext;
    ext = {b, 1'b0};
    if (ext[i+1] && !ext[i]) return ALU_SUB;
    if (!ext[i+1] && ext[i]) return ALU_ADD;
    return ALU_PASS;
  endfunction

  function automatic int expLatency(input logic [N-1:0] b);
    int k;
    k = 0;
    for (int i = 0; i < N; i++) if (boothOp(b, i) != ALU_PASS) k++;
`ifdef BOOTH_SKIP_EN
    return N + k + 1;
`else
    return 2 * N + 1;
`endif
  endfunction

  function automatic logic [2*N-1:0] refMul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] sa, sb, sp;
    sa = {{N{a[N-1]}}, a};
    sb = {{N{b[N-1]}}, b};
    sp = sa * sb;
    return sp;
  endfunction

  // Runs one multiply starting at the current negedge. pulseA/pulseB inject ignored
  // starts in those cycles; startAtDone raises start during the done cycle.
  task automatic runOp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2*N-1:0] expP, input int pulseA, input int pulseB,
                       input bit startAtDone);
    logic [2:0] got[$];
    logic [2:0] want[$];
    int  cyc;
    bit  seenDone;
    int  protoErr;
    bit  opsOk;
    for (int i = 0; i < N; i++) if (boothOp(b, i) != ALU_PASS) want.push_back(boothOp(b, i));
    multiplicandIn = a;
    multiplierIn   = b;
    start          = 1'b1;
    cyc = 0; seenDone = 0; protoErr = 0;
    while (!seenDone && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (aluSetting != ALU_PASS) got.push_back(aluSetting);
      if (aluSetting > ALU_SUB) protoErr++;
      if (!busy) protoErr++;
      if (done) begin
        seenDone = 1;
        if (startAtDone) begin
          start = 1'b1; multiplicandIn = $urandom; multiplierIn = $urandom;
        end
      end else if (cyc == pulseA || cyc == pulseB) begin
        start = 1'b1; multiplicandIn = $urandom; multiplierIn = $urandom;
      end
    end
    opsOk = (got.size() == want.size());
    if (opsOk) foreach (want[i]) if (got[i] !== want[i]) opsOk = 0;
    check({tag, " done_seen"}, 32'(seenDone), 32'd1);
    check({tag, " latency"},   32'(cyc), 32'(expLatency(b)));
    check({tag, " product"},   32'(product), 32'(expP));
    check({tag, " alu_ops"},   32'(opsOk), 32'd1);
    check({tag, " busy/op"},   32'(protoErr), 32'd0);
    // Cycle after done: back in IDLE, pulse over, result held, start at done ignored.
    @(negedge clk);
    check({tag, " post busy"}, 32'(busy), 32'd0);
    check({tag, " post done"}, 32'(done), 32'd0);
    check({tag, " held"},      32'(product), 32'(expP));
    start = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] expP;
  } vecT;

  vecT vecs[8];

  initial begin
    logic [N-1:0] ra, rb;

    vecs[0] = '{8'hFB, 8'h05, 16'hFFE7};  // -5 * 5
    vecs[1] = '{8'h80, 8'h80, 16'h4000};  // guard-bit case
    vecs[2] = '{8'h80, 8'h7F, 16'hC080};
    vecs[3] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[4] = '{8'h00, 8'h5A, 16'h0000};
    vecs[5] = '{8'h5A, 8'h00, 16'h0000};  // all PASS, shortest skip latency
    vecs[6] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[7] = '{8'h7F, 8'h80, 16'hC080};

    reset = 1'b1; start = 1'b0; multiplicandIn = '0; multiplierIn = '0;
    repeat (2) @(negedge clk);
    check("reset busy",         32'(busy), 32'd0);
    check("reset done",         32'(done), 32'd0);
    check("reset product",      32'(product), 32'd0);
    check("reset aluSetting",   32'(aluSetting), 32'(ALU_PASS));
    check("reset multiplicand", 32'(multiplicand), 32'd0);
    check("reset high",         32'(aluProductHigh), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].expP, 0, 0, 0);

    // Starts while busy and during done are dropped.
    runOp("ignore_busy", 8'hFB, 8'h05, 16'hFFE7, 3, 10, 0);
    runOp("ignore_done", 8'h80, 8'h80, 16'h4000, 0, 0, 1);

    // Reset in cycle 6 of an operation.
    multiplicandIn = 8'h55; multiplierIn = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset busy",       32'(busy), 32'd0);
    check("midreset done",       32'(done), 32'd0);
    check("midreset product",    32'(product), 32'd0);
    check("midreset aluSetting", 32'(aluSetting), 32'(ALU_PASS));
    check("midreset high",       32'(aluProductHigh), 32'd0);
    reset = 1'b0;
    runOp("after_reset", 8'h03, 8'hFE, 16'hFFFA, 0, 0, 0);

    // Randomized operands against the arithmetic model.
    for (int k = 0; k < 30; k++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      runOp($sformatf("rand%0d", k), ra, rb, refMul(ra, rb),
            (k % 3 == 0) ? int'($urandom_range(2, 8)) : 0, 0, (k % 5 == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
